frame_buffer: RTL and testbench
===============================

# frame_buffer

Downstream consumer of the `raster` tile stream. Accepts one shaded pixel per cycle over a valid/ready handshake, stores its color in an on-chip frame memory indexed by screen position, and exposes a separate one-cycle-latency read port for scan-out or bench inspection. It also provides a fill sequencer that clears the whole frame to a programmable color; the sequencer runs automatically after reset and on request.

## Interface
- `H_PIXELS`, default 640: frame width in pixels.
- `V_PIXELS`, default 480: frame height in pixels.
- `CNT_BITS`, default 16: width of the dropped-pixel counter.

Ports:
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `vld_in`  in  1: pixel valid from `raster` (`vld_out`).
- `rdy_in`  out  1: ready to `raster` (`rdy_out`).
- `color_in`  in  `COLOR_BITS`: pixel color.
- `pixel_in`  in  `coord_2d_t`: `.x` and `.y` are integer screen coordinates, treated as unsigned.
- `clear_req`  in  1: one-cycle pulse that requests a full-frame fill.
- `clear_color`  in  `COLOR_BITS`: fill color, captured when a request is accepted.
- `clear_busy`  out  1: fill sweep in progress.
- `rd_en`  in  1: read request.
- `rd_x`  in  $clog2(`H_PIXELS`): read column.
- `rd_y`  in  $clog2(`V_PIXELS`): read row.
- `rd_vld`  out  1: read data valid.
- `rd_color`  out  `COLOR_BITS`: read data.
- `drop_cnt`  out  `CNT_BITS`: saturating count of pixels discarded because they fell outside the frame.

## Operation
- Memory: `H_PIXELS*V_PIXELS` words of `COLOR_BITS` each; `addr = y*H_PIXELS + x`. It is simple dual-port: one write port, one read port. Memory contents are not reset.
- FSM has two states, CLEAR and RUN. Reset drives the FSM into CLEAR with fill color 0 and sweep counter 0.
- CLEAR:
  - writes the captured fill color at address `sweep_cnt`, incrementing by one per cycle;
  - exits to RUN on the cycle that writes address `H_PIXELS*V_PIXELS-1`;
  - holds `rdy_in=0` and `clear_busy=1`;
  - ignores `clear_req`.
- RUN:
  - drives `rdy_in=1`;
  - on handshake (`vld_in && rdy_in`): if `x<H_PIXELS && y<V_PIXELS`, writes `color_in` at `addr`; otherwise writes nothing and increments `drop_cnt`, which saturates at all-ones.
  - on `clear_req`: captures `clear_color`, zeroes `sweep_cnt`, and enters CLEAR on the next cycle.
- Simultaneous `clear_req` and handshake in RUN: the pixel is accepted and written that cycle. The sweep then starts and later overwrites it.
- Read port is independent of FSM state:
  - `rd_en` sampled at edge N gives `rd_vld=1` and `rd_color` during cycle N+1;
  - `rd_vld` is low when no read was issued; `rd_color` holds its last value;
  - an out-of-range read address returns 0 with `rd_vld=1`;
  - a read and a write to the same address on the same edge return the old data (read-first).
- Address arithmetic: compute `addr` at full width, using $clog2(`H_PIXELS*V_PIXELS`) bits. Perform the range check on the untruncated `pixel_in` fields before forming `addr`.

## Timing
- Reset values: `rdy_in=0`, `clear_busy=1`, `rd_vld=0`, `rd_color=0`, `drop_cnt=0`.
- Release of reset: the first sweep write happens at the first rising edge after release. `rdy_in` rises exactly `H_PIXELS*V_PIXELS` cycles after that edge.
- `clear_req` accepted at edge N: `rdy_in` and `clear_busy` change in cycle N+1. The sweep spans `H_PIXELS*V_PIXELS` cycles, and `rdy_in` returns high after the last write.
- Pixel write latency is one edge: a pixel accepted at edge N is readable by a `rd_en` sampled at edge N+1.
- Throughput is one pixel per cycle in RUN. `rdy_in` does not depend combinationally on `vld_in`.
- Reset asserted mid-sweep or mid-stream: all outputs return to their reset values immediately. The in-flight pixel is lost, and the post-reset sweep uses color 0.

## Test plan
Use `H_PIXELS=32`, `V_PIXELS=16`.
- Reset, then count cycles → `rdy_in` rises 512 cycles after the first edge following release; reading (31,15) returns 0.
- In RUN, stream pixels (1,1) color 4, (5,1) color 4, (1,5) color 3 → reads return 4, 4, 3 one cycle after `rd_en`; (2,2) still reads 0.
- Send pixel (40,3) and pixel (3,20) → `drop_cnt=2` and no memory word changes; then write (31,15) color 7 → reads back 7.
- `clear_req` with `clear_color=2` in the same cycle as a handshake of pixel (0,0) color 5 → `clear_busy` high for 512 cycles; afterwards every address reads 2.
- Read (4,4) on the same edge that writes (4,4) color 6 → `rd_color` returns the old value; a read one cycle later returns 6.
- Assert `rst_n` low 100 cycles into a `clear_color=3` sweep → outputs go to reset values; the restarted sweep fills 0 and takes the full 512 cycles.

Source files
------------

// File: rtl/frame_buffer.sv
// Frame memory fed by the raster pixel stream, with a full-frame fill sequencer
// and an independent one-cycle-latency read port.
module frame_buffer #(
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480,
  parameter int CNT_BITS   = 16,
  parameter int COLOR_BITS = 8,
  parameter int COORD_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vld_in,
  output logic                        rdy_in,
  input  logic [COLOR_BITS-1:0]       color_in,
  input  logic [2*COORD_BITS-1:0]     pixel_in,
  input  logic                        clear_req,
  input  logic [COLOR_BITS-1:0]       clear_color,
  output logic                        clear_busy,
  input  logic                        rd_en,
  input  logic [$clog2(H_PIXELS)-1:0] rd_x,
  input  logic [$clog2(V_PIXELS)-1:0] rd_y,
  output logic                        rd_vld,
  output logic [COLOR_BITS-1:0]       rd_color,
  output logic [CNT_BITS-1:0]         drop_cnt
);

  localparam int DEPTH     = H_PIXELS * V_PIXELS;
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [31:0] H_LIM = 32'(H_PIXELS);
  localparam logic [31:0] V_LIM = 32'(V_PIXELS);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                  state_q;
  logic [ADDR_BITS-1:0]    sweep_q;
  logic [COLOR_BITS-1:0]   fill_q;
  logic                    rdy_q;
  logic                    busy_q;
  logic [CNT_BITS-1:0]     drop_q;
  logic                    rd_vld_q;
  logic [COLOR_BITS-1:0]   rd_color_q;

  logic [COLOR_BITS-1:0]   mem [DEPTH];

  logic [COORD_BITS-1:0]   pixX;
  logic [COORD_BITS-1:0]   pixY;
  logic                    pixInRange;
  logic [ADDR_BITS-1:0]    pixAddr;
  logic                    handshake;
  logic                    wrEn_d;
  logic [ADDR_BITS-1:0]    wrAddr_d;
  logic [COLOR_BITS-1:0]   wrData_d;
  logic                    rdInRange;
  logic [ADDR_BITS-1:0]    rdAddr;

  // Range check uses the full coordinate width so wrap-around never aliases into the frame.
  assign pixX       = pixel_in[2*COORD_BITS-1:COORD_BITS];
  assign pixY       = pixel_in[COORD_BITS-1:0];
  assign pixInRange = (32'(pixX) < H_LIM) && (32'(pixY) < V_LIM);
  assign pixAddr    = ADDR_BITS'(pixY) * ADDR_BITS'(H_PIXELS) + ADDR_BITS'(pixX);
  assign handshake  = vld_in && rdy_q;

  assign rdInRange  = (32'(rd_x) < H_LIM) && (32'(rd_y) < V_LIM);
  assign rdAddr     = ADDR_BITS'(rd_y) * ADDR_BITS'(H_PIXELS) + ADDR_BITS'(rd_x);

  always_comb begin
    wrEn_d   = 1'b0;
    wrAddr_d = pixAddr;
    wrData_d = color_in;
    if (state_q == CLEAR) begin
      wrEn_d   = 1'b1;
      wrAddr_d = sweep_q;
      wrData_d = fill_q;
    end else if (handshake && pixInRange) begin
      wrEn_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      fill_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (sweep_q == LAST_ADDR) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + ADDR_BITS'(1);
          end
        end
        RUN: begin
          if (clear_req) begin
            state_q <= CLEAR;
            sweep_q <= '0;
            fill_q  <= clear_color;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (handshake && !pixInRange && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_BITS'(1);
    end
  end

  // Contents are never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wrEn_d && rst_n) begin
      mem[wrAddr_d] <= wrData_d;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_color_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) begin
        rd_color_q <= rdInRange ? mem[rdAddr] : '0;
      end
    end
  end

  assign rdy_in     = rdy_q;
  assign clear_busy = busy_q;
  assign drop_cnt   = drop_q;
  assign rd_vld     = rd_vld_q;
  assign rd_color   = rd_color_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: reads push expected colors, a monitor
// pops and compares whenever rd_vld is presented.
module tb_frame_buffer;

  logic        clk;
  logic        rst_n;
  logic        vld_in;
  logic        rdy_in;
  logic [7:0]  color_in;
  logic [31:0] pixel_in;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        rd_en;
  logic [4:0]  rd_x;
  logic [3:0]  rd_y;
  logic        rd_vld;
  logic [7:0]  rd_color;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] expQ[$];

  frame_buffer #(
    .H_PIXELS(32), .V_PIXELS(16), .CNT_BITS(16), .COLOR_BITS(8), .COORD_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
    .color_in(color_in), .pixel_in(pixel_in), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(clear_busy), .rd_en(rd_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_vld(rd_vld), .rd_color(rd_color),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendPx(input int x, input int y, input int c);
    vld_in   = 1'b1;
    pixel_in = {16'(x), 16'(y)};
    color_in = 8'(c);
    tick();
    vld_in   = 1'b0;
  endtask

  task automatic readReq(input int x, input int y, input int exp);
    rd_en = 1'b1;
    rd_x  = 5'(x);
    rd_y  = 4'(y);
    expQ.push_back(8'(exp));
    tick();
    rd_en = 1'b0;
  endtask

  task automatic waitRdy(output int n);
    n = 0;
    while (n < 2000) begin
      tick();
      n++;
      if (rdy_in) break;
    end
  endtask

  // Monitor: every presented read result must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (expQ.size() == 0) begin
        checkOutput("rd_unexpected", 32'(rd_color), 32'hFFFF_FFFF);
      end else begin
        checkOutput("rd_color", 32'(rd_color), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus();
    int n;
    rst_n = 1'b0; vld_in = 1'b0; color_in = '0; pixel_in = '0;
    clear_req = 1'b0; clear_color = '0; rd_en = 1'b0; rd_x = '0; rd_y = '0;
    repeat (3) tick();
    checkOutput("rst_rdy", 32'(rdy_in), 0);
    checkOutput("rst_busy", 32'(clear_busy), 1);
    checkOutput("rst_rd_vld", 32'(rd_vld), 0);
    checkOutput("rst_rd_color", 32'(rd_color), 0);
    checkOutput("rst_drop", 32'(drop_cnt), 0);

    rst_n = 1'b1;
    waitRdy(n);
    checkOutput("init_sweep_cycles", 32'(n), 512);
    checkOutput("init_busy_low", 32'(clear_busy), 0);
    readReq(31, 15, 0);

    sendPx(1, 1, 4);
    sendPx(5, 1, 4);
    sendPx(1, 5, 3);
    readReq(1, 1, 4);
    readReq(5, 1, 4);
    readReq(1, 5, 3);
    readReq(2, 2, 0);

    sendPx(40, 3, 1);
    sendPx(3, 20, 1);
    checkOutput("drop_cnt", 32'(drop_cnt), 2);
    readReq(8, 3, 0);
    readReq(3, 4, 0);
    sendPx(31, 15, 7);
    readReq(31, 15, 7);

    clear_req = 1'b1; clear_color = 8'd2;
    sendPx(0, 0, 5);
    clear_req = 1'b0;
    checkOutput("clr_busy_rise", 32'(clear_busy), 1);
    checkOutput("clr_rdy_fall", 32'(rdy_in), 0);
    n = 0;
    while (n < 2000) begin
      n++;
      tick();
      if (!clear_busy) break;
    end
    checkOutput("clr_busy_cycles", 32'(n), 512);
    checkOutput("clr_rdy_back", 32'(rdy_in), 1);
    for (int a = 0; a < 512; a++) readReq(a % 32, a / 32, 2);

    vld_in = 1'b1; pixel_in = {16'd4, 16'd4}; color_in = 8'd6;
    readReq(4, 4, 2);
    vld_in = 1'b0;
    readReq(4, 4, 6);

    clear_req = 1'b1; clear_color = 8'd3;
    tick();
    clear_req = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rdy", 32'(rdy_in), 0);
    checkOutput("midrst_busy", 32'(clear_busy), 1);
    checkOutput("midrst_rd_color", 32'(rd_color), 0);
    checkOutput("midrst_drop", 32'(drop_cnt), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    waitRdy(n);
    checkOutput("rerst_sweep_cycles", 32'(n), 512);
    readReq(0, 0, 0);
    readReq(10, 2, 0);
    readReq(4, 4, 0);
    readReq(31, 15, 0);
    repeat (3) tick();
    checkOutput("queue_drained", 32'(expQ.size()), 0);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
